cpu_ctrl_fsm: RTL and testbench

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/enter_edge_det.sv | 29 ++
 rtl/cpu_ctrl_fsm.sv | 119 +++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: state codes, opcodes, Asel codes.
// Used by cpu_ctrl_fsm and the datapath.
package cpu_pkg;

  typedef enum logic [3:0] {
    ST_START  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_LOAD   = 4'd8,
    ST_STORE  = 4'd9,
    ST_ADD    = 4'd10,
    ST_SUB    = 4'd11,
    ST_INPUT  = 4'd12,
    ST_JZ     = 4'd13,
    ST_JPOS   = 4'd14,
    ST_HALT   = 4'd15
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_NIN = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  function automatic state_t exec_state(
    input logic [2:0] op
  );
    state_t s;
    s = ST_HALT;
    unique case (op)
      OP_LOAD:  s = ST_LOAD;
      OP_STORE: s = ST_STORE;
      OP_ADD:   s = ST_ADD;
      OP_SUB:   s = ST_SUB;
      OP_INPUT: s = ST_INPUT;
      OP_JZ:    s = ST_JZ;
      OP_JPOS:  s = ST_JPOS;
      OP_HALT:  s = ST_HALT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/enter_edge_det.sv
// Two-flop synchronizer for the operator enter strobe plus a
// rising-edge detector on the synchronized level.
module enter_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Synchronize din and keep the previous synchronized value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Control unit of the simple 8-bit CPU: fetch/decode/execute FSM.
// Define ENTER_EDGE_EN for a synchronized, edge-triggered enter.
import cpu_pkg::*;

module cpu_ctrl_fsm #(
  parameter int OPC_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enter,
  input  logic [OPC_W-1:0] IR75,
  input  logic             Aeq0,
  input  logic             Apos,
  output logic             IRload,
  output logic             PCload,
  output logic             JMPmux,
  output logic             Meminst,
  output logic             MemWr,
  output logic             Aload,
  output logic             Sub,
  output logic [1:0]       Asel,
  output logic             halt,
  output logic [3:0]       StateNo
);

  state_t state;
  logic   accept;

`ifdef ENTER_EDGE_EN
  logic enter_rise;

  enter_edge_det u_enter (
    .clock (clock),
    .reset (reset),
    .din   (enter),
    .rise  (enter_rise)
  );

  assign accept = (state == ST_INPUT) && enter_rise;
`else
  assign accept = (state == ST_INPUT) && enter;
`endif

  // State register: START, then fetch/decode/execute loop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_START;
    end else begin
      unique case (state)
        ST_START:  state <= ST_FETCH;
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: state <= exec_state(IR75[2:0]);
        ST_INPUT:  state <= accept ? ST_FETCH : ST_INPUT;
        ST_HALT:   state <= ST_HALT;
        ST_LOAD,
        ST_STORE,
        ST_ADD,
        ST_SUB,
        ST_JZ,
        ST_JPOS:   state <= ST_FETCH;
        default:   state <= ST_START;
      endcase
    end
  end

  // Strobes decoded from state; jumps and INPUT also use live flags.
  always_comb begin
    IRload  = 1'b0;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Asel    = ASEL_ALU;
    halt    = 1'b0;
    unique case (state)
      ST_FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      ST_DECODE: Meminst = 1'b1;
      ST_LOAD: begin
        Aload = 1'b1;
        Asel  = ASEL_MEM;
      end
      ST_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      ST_ADD: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
      end
      ST_SUB: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
        Sub     = 1'b1;
      end
      ST_INPUT: begin
        Asel  = ASEL_NIN;
        Aload = accept;
      end
      ST_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      ST_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      ST_HALT: halt = 1'b1;
      default: ;
    endcase
  end

  assign StateNo = state;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm against an
// instruction-level reference model.
module tb_cpu_ctrl_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enter = 1'b0;
  logic [2:0] IR75  = 3'd0;
  logic       Aeq0  = 1'b0;
  logic       Apos  = 1'b0;
  logic       IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub;
  logic [1:0] Asel;
  logic       halt;
  logic [3:0] StateNo;

  int errors = 0;
  int checks = 0;

  // model: ph 0=start 1=fetch 2=decode 3=execute; mop = latched opcode
  int         ph = 0;
  logic [2:0] mop = 3'd0;
  logic       h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;

  logic [13:0] obs;
  assign obs = {StateNo, halt, Asel, IRload, PCload, JMPmux,
                Meminst, MemWr, Aload, Sub};

  cpu_ctrl_fsm #(.OPC_W(3)) dut (
    .clock   (clock),
    .reset   (reset),
    .enter   (enter),
    .IR75    (IR75),
    .Aeq0    (Aeq0),
    .Apos    (Apos),
    .IRload  (IRload),
    .PCload  (PCload),
    .JMPmux  (JMPmux),
    .Meminst (Meminst),
    .MemWr   (MemWr),
    .Aload   (Aload),
    .Sub     (Sub),
    .Asel    (Asel),
    .halt    (halt),
    .StateNo (StateNo)
  );

  always #5 clock = ~clock;

  function automatic logic accepted();
`ifdef ENTER_EDGE_EN
    return (ph == 3) && (mop == 3'd4) && h1 && !h2;
`else
    return (ph == 3) && (mop == 3'd4) && enter;
`endif
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [3:0] code;
    logic [1:0] as;
    logic ex, h, irl, pcl, jmp, mi, mw, al, sb;
    ex   = (ph == 3);
    code = (ph == 0) ? 4'd0 : (ph == 1) ? 4'd1 :
           (ph == 2) ? 4'd2 : 4'd8 + {1'b0, mop};
    irl  = (ph == 1);
    pcl  = (ph == 1) || (ex && mop == 3'd5 && Aeq0) ||
           (ex && mop == 3'd6 && Apos);
    jmp  = ex && (mop == 3'd5 || mop == 3'd6);
    mi   = (ph == 2) || (ex && mop >= 3'd1 && mop <= 3'd3);
    mw   = ex && mop == 3'd1;
    al   = ex && (mop == 3'd0 || mop == 3'd2 || mop == 3'd3 ||
                  (mop == 3'd4 && accepted()));
    sb   = ex && mop == 3'd3;
    as   = !ex ? 2'b00 : (mop == 3'd0) ? 2'b10 :
           (mop == 3'd4) ? 2'b01 : 2'b00;
    h    = ex && mop == 3'd7;
    return {code, h, as, irl, pcl, jmp, mi, mw, al, sb};
  endfunction

  // advance one clock (called at a falling edge), update model
  task automatic tick();
    logic acc;
    @(posedge clock);
    if (reset) begin
      ph = 0;
      h0 = 0; h1 = 0; h2 = 0;
    end else begin
      acc = accepted();
      case (ph)
        0: ph = 1;
        1: ph = 2;
        2: begin mop = IR75; ph = 3; end
        default: begin
          if (mop == 3'd7) ph = 3;
          else if (mop == 3'd4 && !acc) ph = 3;
          else ph = 1;
        end
      endcase
      h2 = h1; h1 = h0; h0 = enter;
    end
    @(negedge clock);
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    #1;
    ph = 0;
    h0 = 0; h1 = 0; h2 = 0;
  endtask

  task automatic test_reset();
    assert_reset();
    checks++;
    if (obs !== 14'd0) begin
      errors++;
      $display("FAIL reset_now: got %h want %h", obs, 14'd0);
    end
    tick();
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset_held: got %h want %h", obs, exp_vec());
    end
    reset = 1'b0;
    tick();
    checks++;
    if (StateNo !== 4'd1) begin
      errors++;
      $display("FAIL reset_first_fetch: got %0d want 1", StateNo);
    end
  endtask

  task automatic test_load_seq();
    logic [3:0] seq [6];
    seq = '{4'd1, 4'd2, 4'd8, 4'd1, 4'd2, 4'd8};
    IR75 = 3'd0;
    assert_reset();
    checks++;
    if (StateNo !== 4'd0) begin
      errors++;
      $display("FAIL load_seq_start: got %0d want 0", StateNo);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (StateNo !== seq[i] || obs !== exp_vec()) begin
        errors++;
        $display("FAIL load_seq[%0d]: got %h want %h (state %0d)",
                 i, obs, exp_vec(), seq[i]);
      end
    end
  endtask

  task automatic test_jumps();
    for (int k = 0; k < 4; k++) begin
      IR75 = (k < 2) ? 3'd5 : 3'd6;
      Aeq0 = (k == 0);
      Apos = (k == 2);
      assert_reset();
      reset = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (StateNo !== {1'b1, IR75} || JMPmux !== 1'b1 ||
          PCload !== (k == 0 || k == 2) || obs !== exp_vec()) begin
        errors++;
        $display("FAIL jump[%0d]: got %h want %h", k, obs, exp_vec());
      end
      tick();
      checks++;
      if (StateNo !== 4'd1) begin
        errors++;
        $display("FAIL jump_next[%0d]: got %0d want 1", k, StateNo);
      end
    end
    Aeq0 = 0;
    Apos = 0;
  endtask

  task automatic test_input();
    int pulses;
    int budget;
    IR75  = 3'd4;
    enter = 1'b1;
    assert_reset();
    reset = 1'b0;
    tick(); tick(); tick();
`ifdef ENTER_EDGE_EN
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (StateNo !== 4'd12 || Aload !== 1'b0 || Asel !== 2'b01) begin
        errors++;
        $display("FAIL input_held[%0d]: got %h want %h",
                 i, obs, exp_vec());
      end
      tick();
    end
    enter = 1'b0;
    tick(); tick(); tick();
    enter = 1'b1;
    pulses = 0;
    budget = 0;
    while (StateNo == 4'd12 && budget < 8) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL input_edge: got %h want %h", obs, exp_vec());
      end
      if (Aload === 1'b1 && Asel === 2'b01) pulses++;
      tick();
      budget++;
    end
    checks++;
    if (pulses != 1 || StateNo !== 4'd1) begin
      errors++;
      $display("FAIL input_accept: pulses %0d state %0d want 1 and 1",
               pulses, StateNo);
    end
`else
    pulses = 0;
    budget = 0;
    checks++;
    if (StateNo !== 4'd12 || Aload !== 1'b1 || Asel !== 2'b01) begin
      errors++;
      $display("FAIL input_level: got %h want %h", obs, exp_vec());
    end
    tick();
    checks++;
    if (StateNo !== 4'd1) begin
      errors++;
      $display("FAIL input_level_next: got %0d want 1", StateNo);
    end
`endif
    enter = 1'b0;
  endtask

  task automatic test_halt();
    IR75 = 3'd7;
    assert_reset();
    reset = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 100; i++) begin
      enter = i[0];
      Aeq0 = i[1];
      Apos = i[2];
      checks++;
      if (StateNo !== 4'd15 || halt !== 1'b1 ||
          obs !== {4'd15, 1'b1, 9'd0}) begin
        errors++;
        $display("FAIL halt[%0d]: got %h want %h",
                 i, obs, {4'd15, 1'b1, 9'd0});
      end
      tick();
    end
    enter = 0; Aeq0 = 0; Apos = 0;
    #2;
    assert_reset();
    checks++;
    if (StateNo !== 4'd0 || halt !== 1'b0 || obs !== 14'd0) begin
      errors++;
      $display("FAIL halt_reset: got %h want %h", obs, 14'd0);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_add();
    IR75 = 3'd2;
    assert_reset();
    reset = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (StateNo !== 4'd10 || Aload !== 1'b1) begin
      errors++;
      $display("FAIL add_state: got %h want %h", obs, exp_vec());
    end
    #2;
    assert_reset();
    checks++;
    if (Aload !== 1'b0 || StateNo !== 4'd0) begin
      errors++;
      $display("FAIL add_reset: got %h want %h", obs, 14'd0);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (StateNo !== 4'd1) begin
      errors++;
      $display("FAIL add_restart: got %0d want 1", StateNo);
    end
  endtask

  task automatic test_random();
    int halted;
    halted = 0;
    assert_reset();
    reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      IR75  = 3'($urandom_range(0, 7));
      Aeq0  = 1'($urandom);
      Apos  = Aeq0 ? 1'b0 : 1'($urandom);
      enter = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h",
                 i, obs, exp_vec());
      end
      if (ph == 3 && mop == 3'd7) halted++;
      if (halted > 3) begin
        halted = 0;
        assert_reset();
        checks++;
        if (obs !== 14'd0) begin
          errors++;
          $display("FAIL random_reset[%0d]: got %h want 0", i, obs);
        end
        reset = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_seq();
    test_jumps();
    test_input();
    test_halt();
    test_reset_mid_add();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
